uart_rx: RTL and testbench

Serial receiver for the SOC UART: samples the asynchronous RX line against the baud generator's oversampling tick and recovers 8N1 frames. It hands each byte to the Wishbone UART controller through a one-deep holding register, with valid/ack handshake and error flags. It feeds the controller's RX and CTL registers and is the receive-side counterpart of the existing transmitter.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_rx_sampler.sv | 36 +++
 rtl/uart_rx.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, the transmitter and the baud generator.
//   uart_rx_state_t          receiver FSM state encoding
//   UART_OVERSAMPLE_DEFAULT  default number of baud ticks per bit
//   uart_vote_first/last()   first/last of the three majority-vote ticks within a bit
// The parity state only exists when UART_RX_PARITY_EN is defined.
package uart_pkg;

    localparam int unsigned UART_OVERSAMPLE_DEFAULT = 16;

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StStart    = 3'd1,
        StData     = 3'd2,
`ifdef UART_RX_PARITY_EN
        StParity   = 3'd3,
`endif
        StStop     = 3'd4,
        StWaitHigh = 3'd5
    } uart_rx_state_t;

    // Samples are taken at ticks os/2-1, os/2 and os/2+1 of each bit; the vote is
    // complete on the last of them.
    function automatic int unsigned uart_vote_first(input int unsigned os);
        return os / 2 - 1;
    endfunction

    function automatic int unsigned uart_vote_last(input int unsigned os);
        return os / 2 + 1;
    endfunction

    localparam int unsigned UART_VOTE_FIRST_DEFAULT = UART_OVERSAMPLE_DEFAULT / 2 - 1;
    localparam int unsigned UART_VOTE_LAST_DEFAULT  = UART_OVERSAMPLE_DEFAULT / 2 + 1;

endpackage

// File: rtl/uart_rx_sampler.sv
// RX line conditioning: 2-FF synchronizer plus a 3-sample majority vote.
//   clk, reset  system clock, asynchronous active-low reset
//   i_tick      oversampling tick
//   i_rx        raw asynchronous serial line
//   o_level     synchronized line level
//   o_vote      majority of the levels seen on the last three ticks (current one included)
module uart_rx_sampler (
    input  logic clk,
    input  logic reset,
    input  logic i_tick,
    input  logic i_rx,
    output logic o_level,
    output logic o_vote
);

    logic [1:0] sync_q;
    // Levels from the two previous ticks; the live level is the third sample, so the
    // vote is complete on the very tick that takes the last sample.
    logic [1:0] hist_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= 2'b11;
            hist_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], i_rx};
            if (i_tick) begin
                hist_q <= {hist_q[0], sync_q[1]};
            end
        end
    end

    assign o_level = sync_q[1];
    assign o_vote  = (hist_q[1] & hist_q[0]) | (hist_q[1] & o_level) | (hist_q[0] & o_level);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: recovers LSB-first frames from the oversampled RX line and hands each
// byte over through a one-deep holding register with valid/ack and sticky error flags.
//   clk, reset    system clock, asynchronous active-low reset
//   i_tick        one-clk enable at OVERSAMPLE x baud
//   i_rx          raw serial line, idles high
//   i_ack         consumer took o_data; clears o_valid and all error flags
//   o_data        last accepted byte, held until the next one
//   o_valid       o_data is unread
//   o_frame_err   sticky, stop bit sampled low
//   o_overrun     sticky, a byte was dropped while o_valid was set
//   o_parity_err  sticky, parity mismatch (only with UART_RX_PARITY_EN)
// Build option: define UART_RX_PARITY_EN to add a parity bit after the data bits;
// PARITY_ODD then selects odd (1) or even (0) parity.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE_DEFAULT,
    parameter int unsigned DATA_BITS  = 8
`ifdef UART_RX_PARITY_EN
    , parameter bit        PARITY_ODD = 1'b0
`endif
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_tick,
    input  logic                 i_rx,
    input  logic                 i_ack,
    output logic [DATA_BITS-1:0] o_data,
    output logic                 o_valid,
    output logic                 o_frame_err,
`ifdef UART_RX_PARITY_EN
    output logic                 o_parity_err,
`endif
    output logic                 o_overrun
);

    localparam int unsigned     CntW     = $clog2(OVERSAMPLE);
    localparam logic [CntW-1:0] VoteTick = CntW'(uart_vote_last(OVERSAMPLE));
    localparam logic [CntW-1:0] LastTick = CntW'(OVERSAMPLE - 1);
    localparam logic [2:0]      LastBit  = 3'(DATA_BITS - 1);

    logic level, vote;

    uart_rx_sampler u_sampler (
        .clk    (clk),
        .reset  (reset),
        .i_tick (i_tick),
        .i_rx   (i_rx),
        .o_level(level),
        .o_vote (vote)
    );

    uart_rx_state_t       state_q, state_d;
    logic [CntW-1:0]      tick_cnt_q, tick_cnt_d, tick_idx;
    logic [2:0]           bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 vote_pt, bit_end, deliver, frame_set;

    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
`ifdef UART_RX_PARITY_EN
    logic                 par_bad_q, par_bad_d;
    logic                 parity_err_q, parity_err_d;
`endif

    // tick_cnt_q is the index of the last tick seen in the current bit; the start
    // detection tick is index 0, so tick_idx is the index of the tick now presented.
    assign tick_idx = tick_cnt_q + CntW'(1);
    assign vote_pt  = i_tick && (tick_idx == VoteTick);
    assign bit_end  = i_tick && (tick_idx == LastTick);

    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        deliver    = 1'b0;
        frame_set  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_d  = par_bad_q;
`endif
        if (i_tick && state_q != StIdle && state_q != StWaitHigh) begin
            tick_cnt_d = tick_idx;
        end
        unique case (state_q)
            StIdle: begin
                if (i_tick && !level) begin
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = StStart;
                end
            end
            StStart: begin
                if (vote_pt && vote) begin
                    state_d = StIdle;   // false start
                end else if (bit_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (vote_pt) begin
                    shift_d = {vote, shift_q[DATA_BITS-1:1]};
                end
                if (bit_end) begin
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == LastBit) begin
`ifdef UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (vote_pt) begin
                    par_bad_d = (^shift_q) ^ vote ^ PARITY_ODD;
                end
                if (bit_end) begin
                    state_d = StStop;
                end
            end
`endif
            // Acting at the vote point lets the next start edge be seen half a bit early.
            StStop: begin
                if (vote_pt) begin
                    if (vote) begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end else begin
                        frame_set = 1'b1;
                        state_d   = StWaitHigh;
                    end
                end
            end
            StWaitHigh: begin
                if (i_tick && level) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        if (i_ack) begin
            valid_d     = 1'b0;
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (deliver) begin
            if (!valid_q || i_ack) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
        if (frame_set) begin
            frame_err_d = 1'b1;
        end
`ifdef UART_RX_PARITY_EN
        parity_err_d = parity_err_q;
        if (i_ack) begin
            parity_err_d = 1'b0;
        end
        if (deliver && par_bad_q) begin
            parity_err_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign o_parity_err = parity_err_q;
`endif

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at OVERSAMPLE=16, 8 data bits, one baud tick every 4 clk.
module tb_uart_rx;

    localparam int ClkPerTick = 4;
    localparam int ClkPerBit  = 16 * ClkPerTick;

    logic       clk = 1'b0;
    logic       reset;
    logic       i_tick;
    logic       i_rx;
    logic       i_ack;
    logic [7:0] o_data;
    logic       o_valid;
    logic       o_frame_err;
    logic       o_overrun;
`ifdef UART_RX_PARITY_EN
    logic       o_parity_err;
    bit         tb_par_flip = 1'b0;
    bit         m_pe;
`endif

    uart_rx dut (
        .clk         (clk),
        .reset       (reset),
        .i_tick      (i_tick),
        .i_rx        (i_rx),
        .i_ack       (i_ack),
        .o_data      (o_data),
        .o_valid     (o_valid),
        .o_frame_err (o_frame_err),
`ifdef UART_RX_PARITY_EN
        .o_parity_err(o_parity_err),
`endif
        .o_overrun   (o_overrun)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Tick is high on posedges p with (p-1) % 4 == 0.
    initial begin
        i_tick = 1'b0;
        forever begin
            @(negedge clk);
            i_tick = ((cyc % ClkPerTick) == 0);
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endfunction

    // Reference model of the holding register.
    bit       m_valid, m_fe, m_ov;
    bit [7:0] m_data;

    typedef struct {
        logic [7:0] data;
        int         cyc;
    } exp_t;
    exp_t sb_q[$];

    // Monitor: a delivery is o_valid rising, or o_valid staying up across an ack.
    logic prev_valid = 1'b0;
    initial begin
        exp_t e;
        int   depth;
        forever begin
            @(posedge clk);
            #1;
            if (reset && o_valid && (!prev_valid || i_ack)) begin
                depth = sb_q.size();
                check("delivery_expected", 32'(depth != 0), 1);
                if (depth != 0) begin
                    e = sb_q.pop_front();
                    check("rx_data", 32'(o_data), 32'(e.data));
                    check("rx_latency_cyc", cyc, e.cyc);
                end
            end
            prev_valid = o_valid;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_ack();
        @(negedge clk);
        i_ack   = 1'b1;
        m_valid = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
`ifdef UART_RX_PARITY_EN
        m_pe    = 1'b0;
`endif
        @(negedge clk);
        i_ack = 1'b0;
    endtask

    task automatic check_state(input string tag);
        check({tag, ".valid"}, 32'(o_valid), 32'(m_valid));
        check({tag, ".data"}, 32'(o_data), 32'(m_data));
        check({tag, ".frame_err"}, 32'(o_frame_err), 32'(m_fe));
        check({tag, ".overrun"}, 32'(o_overrun), 32'(m_ov));
`ifdef UART_RX_PARITY_EN
        check({tag, ".parity_err"}, 32'(o_parity_err), 32'(m_pe));
`endif
    endtask

    // Sends one frame. The start edge is seen after the 2-clk synchronizer on the next
    // tick; the stop vote lands on the tick 16*stop_index+9 ticks after that detection.
    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit ack_at_vote);
        logic [10:0] bits;
        int          nb, n, p, vote_p;
        bits    = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = d[i];
        nb = 9;
`ifdef UART_RX_PARITY_EN
        bits[9] = (^d) ^ tb_par_flip;
        nb      = 10;
`endif
        bits[nb] = stop_ok;
        nb++;
        @(negedge clk);
        n = cyc;
        p = n + 3;
        while (((p - 1) % ClkPerTick) != 0) p++;
        vote_p = p + ((nb - 1) * 16 + 9) * ClkPerTick;
        if (ack_at_vote) begin
            m_valid = 1'b0;
            m_fe    = 1'b0;
            m_ov    = 1'b0;
`ifdef UART_RX_PARITY_EN
            m_pe    = 1'b0;
`endif
        end
        if (stop_ok) begin
            if (!m_valid) begin
                m_valid = 1'b1;
                m_data  = d;
                sb_q.push_back('{d, vote_p});
            end else begin
                m_ov = 1'b1;
            end
`ifdef UART_RX_PARITY_EN
            if (tb_par_flip) m_pe = 1'b1;
`endif
        end else begin
            m_fe = 1'b1;
        end
        for (int b = 0; b < nb; b++) begin
            for (int c = 0; c < ClkPerBit; c++) begin
                i_rx  = bits[b];
                i_ack = ack_at_vote && (cyc == vote_p - 1);
                @(negedge clk);
            end
        end
        i_ack = 1'b0;
    endtask

    initial begin
        logic [7:0] d;
        int         mode;
        reset   = 1'b0;
        i_rx    = 1'b1;
        i_ack   = 1'b0;
        m_valid = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
        m_data  = '0;
`ifdef UART_RX_PARITY_EN
        m_pe    = 1'b0;
`endif
        idle(5);
        reset = 1'b1;
        idle(10);
        check_state("reset");

        send_frame(8'hA5, 1'b1, 1'b0);
        idle(64);
        check_state("a5");

        // 4-tick glitch: false start, nothing delivered.
        @(negedge clk);
        i_rx = 1'b0;
        idle(4 * ClkPerTick);
        i_rx = 1'b1;
        idle(128);
        check_state("glitch");
        do_ack();
        send_frame(8'h3C, 1'b1, 1'b0);
        idle(32);
        check_state("3c");
        do_ack();

        // Stop bit low, then a long break; exactly one frame error, no delivery.
        send_frame(8'h55, 1'b0, 1'b0);
        idle(30 * ClkPerBit);
        check_state("break");
        i_rx = 1'b1;
        idle(2 * ClkPerBit);
        send_frame(8'h12, 1'b1, 1'b0);
        idle(32);
        check_state("after_break");
        do_ack();
        check_state("ack_fe");

        // Overrun.
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0);
        idle(32);
        check_state("overrun");
        do_ack();
        check_state("ack_ovr");

        // Ack in the same cycle the next byte completes.
        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        idle(32);
        check_state("ack_same");

        // Leave a flag set, then reset in the middle of 0xFF's data bits.
        send_frame(8'h33, 1'b1, 1'b0);
        @(negedge clk);
        i_rx = 1'b0;
        idle(ClkPerBit);
        i_rx = 1'b1;
        idle(3 * ClkPerBit);
        reset   = 1'b0;
        m_valid = 1'b0;
        m_fe    = 1'b0;
        m_ov    = 1'b0;
        m_data  = '0;
        idle(3);
        check_state("mid_reset");
        reset = 1'b1;
        idle(7 * ClkPerBit);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(32);
        check_state("after_reset");
        do_ack();

`ifdef UART_RX_PARITY_EN
        tb_par_flip = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0);
        tb_par_flip = 1'b0;
        idle(32);
        check_state("parity");
        do_ack();
`endif

        // Random bytes with random consumer behaviour.
        for (int i = 0; i < 12; i++) begin
            d    = 8'($urandom);
            mode = int'($urandom_range(0, 2));
            send_frame(d, 1'b1, mode == 2);
            if (mode == 0) do_ack();
            idle(int'($urandom_range(0, 40)));
            check_state("rand");
        end

        idle(200);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
